// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - command sequencer driving a 6-bit 4-op combinational ALU
//
// Purpose: buffers op/operand commands in a small FIFO, issues each one to an
// external combinational ALU (A = accumulator, B = operand, C = op), captures F
// back into the accumulator after SETTLE cycles and returns the accumulator on
// a result handshake when a command marked last retires.
//
// Optional: `define ALUSEQ_OVF_EN builds the sticky signed-overflow flag; when
// undefined res_ovf is tied to 0.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready = FIFO not full)
//   cmd_op, cmd_load, cmd_operand  op code, direct-load flag, B operand/load value
//   cmd_last                       retiring this command emits a result
//   alu_a, alu_b, alu_c            ALU inputs (alu_a is the accumulator)
//   alu_f                          ALU result
//   res_valid/res_ready            result handshake
//   res_data, res_ovf              result value, sticky signed overflow
//   busy                           sequencer active or FIFO not empty

module alu_seq_ctrl #(
    parameter int WIDTH      = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_operand,
    input  logic             cmd_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_c,
    input  logic [WIDTH-1:0] alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RETIRE,
        S_RESULT
    } state_t;

    state_t state, state_nxt;

    // Command FIFO: entry = {last, load, op, operand}
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;

    // Command being executed
    logic [1:0]       cur_op;
    logic             cur_load;
    logic [WIDTH-1:0] cur_operand;
    logic             cur_last;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] alu_b_r;
    logic [1:0]       alu_c_r;
    logic [2:0]       settle_cnt;
    logic             res_valid_r;
    logic [WIDTH-1:0] res_data_r;
    logic             capture;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && !empty;
    assign capture   = (state == S_WAIT) && (settle_cnt == 3'd0);

    assign alu_a     = acc;
    assign alu_b     = alu_b_r;
    assign alu_c     = alu_c_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign busy      = (state != S_IDLE) || !empty;

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_last, cmd_load, cmd_op, cmd_operand};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!empty) state_nxt = S_ISSUE;
            S_ISSUE:  state_nxt = cur_load ? S_RETIRE : S_WAIT;
            S_WAIT:   if (settle_cnt == 3'd0) state_nxt = S_RETIRE;
            S_RETIRE: state_nxt = cur_last ? S_RESULT : S_IDLE;
            S_RESULT: if (res_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op      <= 2'b00;
            cur_load    <= 1'b0;
            cur_operand <= '0;
            cur_last    <= 1'b0;
            acc         <= '0;
            alu_b_r     <= '0;
            alu_c_r     <= 2'b01;
            settle_cnt  <= 3'd0;
            res_valid_r <= 1'b0;
            res_data_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {cur_last, cur_load, cur_op, cur_operand} <= mem[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    if (cur_load) begin
                        acc <= cur_operand;
                    end else begin
                        alu_b_r    <= cur_operand;
                        alu_c_r    <= cur_op;
                        settle_cnt <= 3'(SETTLE - 1);
                    end
                end
                S_WAIT: begin
                    // ALU inputs stay untouched here so F can settle.
                    if (settle_cnt == 3'd0) acc <= alu_f;
                    else                    settle_cnt <= settle_cnt - 3'd1;
                end
                S_RETIRE: begin
                    if (cur_last) begin
                        res_data_r  <= acc;
                        res_valid_r <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                        acc         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALUSEQ_OVF_EN
    logic ovf_sticky, res_ovf_r, ovf_now;
    logic a_s, b_s, f_s;

    assign a_s = acc[WIDTH-1];
    assign b_s = alu_b_r[WIDTH-1];
    assign f_s = alu_f[WIDTH-1];

    // Signed overflow from sign bits only: add (A+B+1) and subtract (A-B).
    always_comb begin
        ovf_now = 1'b0;
        case (alu_c_r)
            2'b00:   ovf_now = (a_s == b_s) && (f_s != a_s);
            2'b11:   ovf_now = (a_s != b_s) && (f_s != a_s);
            default: ovf_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            res_ovf_r  <= 1'b0;
        end else begin
            if (capture && ovf_now) ovf_sticky <= 1'b1;
            if (state == S_RETIRE && cur_last) res_ovf_r <= ovf_sticky;
            if (state == S_RESULT && res_ready) begin
                ovf_sticky <= 1'b0;
                res_ovf_r  <= 1'b0;
            end
        end
    end

    assign res_ovf = res_ovf_r;
`else
    assign res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl

module tb_alu_seq_ctrl;

`ifdef ALUSEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance with SETTLE=1
    logic       cmd_valid, cmd_ready, cmd_load, cmd_last;
    logic [1:0] cmd_op, alu_c;
    logic [5:0] cmd_operand, alu_a, alu_b, alu_f, res_data;
    logic       res_valid, res_ready, res_ovf, busy;

    // Instance with SETTLE=3
    logic       cmd_valid_3, cmd_ready_3, cmd_load_3, cmd_last_3;
    logic [1:0] cmd_op_3, alu_c_3;
    logic [5:0] cmd_operand_3, alu_a_3, alu_b_3, alu_f_3, res_data_3;
    logic       res_valid_3, res_ready_3, res_ovf_3, busy_3;

    function automatic logic [5:0] alu_fn(input logic [5:0] a, input logic [5:0] b,
                                          input logic [1:0] c);
        case (c)
            2'b00:   return a + b + 6'd1;
            2'b01:   return a;
            2'b10:   return a & b;
            default: return a - b;
        endcase
    endfunction

    assign alu_f   = alu_fn(alu_a, alu_b, alu_c);
    assign alu_f_3 = alu_fn(alu_a_3, alu_b_3, alu_c_3);

    alu_seq_ctrl #(.WIDTH(6), .FIFO_DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_load(cmd_load), .cmd_operand(cmd_operand), .cmd_last(cmd_last),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_f(alu_f),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ovf(res_ovf), .busy(busy)
    );

    alu_seq_ctrl #(.WIDTH(6), .FIFO_DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3), .cmd_op(cmd_op_3),
        .cmd_load(cmd_load_3), .cmd_operand(cmd_operand_3), .cmd_last(cmd_last_3),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_c(alu_c_3), .alu_f(alu_f_3),
        .res_valid(res_valid_3), .res_ready(res_ready_3), .res_data(res_data_3),
        .res_ovf(res_ovf_3), .busy(busy_3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int sel, input bit ld, input bit [1:0] op,
                        input bit [5:0] opd, input bit last);
        int n = 0;
        if (sel == 0) begin
            cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opd; cmd_last = last;
            while (!cmd_ready && n < 200) begin tick(); n++; end
        end else begin
            cmd_valid_3 = 1'b1; cmd_load_3 = ld; cmd_op_3 = op; cmd_operand_3 = opd; cmd_last_3 = last;
            while (!cmd_ready_3 && n < 200) begin tick(); n++; end
        end
        if (n >= 200) check("push_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_valid_3 = 1'b0;
    endtask

    task automatic get_result(input string tag, input bit [5:0] exp_d, input bit exp_o,
                              input int hold);
        int n = 0;
        bit stable = 1'b1;
        logic [5:0] d0;
        logic o0;
        while (!res_valid && n < 100) begin tick(); n++; end
        check($sformatf("%s_valid", tag), int'(res_valid), 1);
        d0 = res_data;
        o0 = res_ovf;
        repeat (hold) begin
            tick();
            if (!res_valid || res_data != d0 || res_ovf != o0) stable = 1'b0;
        end
        check($sformatf("%s_stable", tag), int'(stable), 1);
        check($sformatf("%s_data", tag), int'(res_data), int'(exp_d));
        check($sformatf("%s_ovf", tag), int'(res_ovf), int'(exp_o));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check($sformatf("%s_valid_drop", tag), int'(res_valid), 0);
        check($sformatf("%s_acc_clear", tag), int'(alu_a), 0);
    endtask

    // Reference model: accumulator semantics from the op definitions, with
    // overflow judged by whether the exact signed result fits in 6 bits.
    bit [5:0] macc;
    bit       movf;

    task automatic model_step(input bit ld, input bit [1:0] op, input bit [5:0] opd);
        int ia, ib, r;
        if (ld) begin
            macc = opd;
        end else begin
            ia = $signed(macc);
            ib = $signed(opd);
            case (op)
                2'b00:   r = ia + ib + 1;
                2'b01:   r = ia;
                2'b10:   r = ia & ib;
                default: r = ia - ib;
            endcase
            if ((op == 2'b00 || op == 2'b11) && (r > 31 || r < -32)) movf = 1'b1;
            macc = r[5:0];
        end
    endtask

    typedef struct {
        bit       ld;
        bit [1:0] op;
        bit [5:0] opd;
        bit       last;
        bit [5:0] exp_d;
        bit       exp_o;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit stable;
        bit seen;
        int len;
        bit ld, last;
        bit [1:0] op;
        bit [5:0] opd;

        // chain: load 5; 5+2+1 = 8; 8-3 = 5
        tbl.push_back('{1'b1, 2'b00, 6'd5,  1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b00, 6'd2,  1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b11, 6'd3,  1'b1, 6'd5,  1'b0});
        // wrap: 31+0+1 = -32
        tbl.push_back('{1'b1, 2'b00, 6'd31, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b00, 6'd0,  1'b1, 6'd32, 1'b1});
        // AND/pass: 101101 & 011011 = 001001
        tbl.push_back('{1'b1, 2'b00, 6'd45, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b10, 6'd27, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b01, 6'd63, 1'b1, 6'd9,  1'b0});
        // subtract wrap: -32-1 = 31
        tbl.push_back('{1'b1, 2'b00, 6'd32, 1'b0, 6'd0,  1'b0});
        tbl.push_back('{1'b0, 2'b11, 6'd1,  1'b1, 6'd31, 1'b1});

        rst_n = 1'b0;
        cmd_valid = 0; cmd_load = 0; cmd_op = 0; cmd_operand = 0; cmd_last = 0; res_ready = 0;
        cmd_valid_3 = 0; cmd_load_3 = 0; cmd_op_3 = 0; cmd_operand_3 = 0; cmd_last_3 = 0;
        res_ready_3 = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_data", int'(res_data), 0);
        check("rst_res_ovf", int'(res_ovf), 0);
        check("rst_alu_a", int'(alu_a), 0);
        check("rst_alu_b", int'(alu_b), 0);
        check("rst_alu_c", int'(alu_c), 1);

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            push(0, tbl[i].ld, tbl[i].op, tbl[i].opd, tbl[i].last);
            if (tbl[i].last) get_result($sformatf("tbl%0d", i), tbl[i].exp_d,
                                        tbl[i].exp_o & OVF_ON, 3);
        end

        // Backpressure: result pending, FIFO fills, fifth command refused
        push(0, 1'b1, 2'b00, 6'd1, 1'b1);
        for (int n = 0; n < 20 && !res_valid; n++) tick();
        push(0, 1'b1, 2'b00, 6'd3,  1'b0);
        push(0, 1'b0, 2'b00, 6'd4,  1'b0);
        push(0, 1'b0, 2'b10, 6'd12, 1'b0);
        push(0, 1'b0, 2'b11, 6'd1,  1'b0);
        check("bp_full_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 2'b01; cmd_operand = 6'd17; cmd_last = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (!res_valid || res_data != 6'd1 || cmd_ready) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        check("bp_hold", int'(stable), 1);
        get_result("bp_first", 6'd1, 1'b0, 0);
        push(0, 1'b0, 2'b01, 6'd17, 1'b1);
        get_result("bp_chain", 6'd7, 1'b0, 2);

        // Random chains against the reference model
        for (int c = 0; c < 30; c++) begin
            macc = '0;
            movf = 1'b0;
            len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                ld   = ($urandom_range(0, 3) == 0);
                op   = 2'($urandom);
                opd  = 6'($urandom);
                last = (j == len - 1);
                model_step(ld, op, opd);
                push(0, ld, op, opd, last);
            end
            get_result($sformatf("rnd%0d", c), macc, movf & OVF_ON, $urandom_range(0, 3));
        end

        // Reset while SETTLE=3 instance is in WAIT with 3 commands queued
        push(1, 1'b0, 2'b00, 6'd7, 1'b0);
        push(1, 1'b1, 2'b00, 6'd9, 1'b0);
        push(1, 1'b0, 2'b00, 6'd2, 1'b0);
        push(1, 1'b0, 2'b01, 6'd0, 1'b1);
        check("mid_busy", int'(busy_3), 1);
        check("mid_alu_b", int'(alu_b_3), 7);
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", int'(cmd_ready_3), 1);
        check("arst_busy", int'(busy_3), 0);
        check("arst_res_valid", int'(res_valid_3), 0);
        check("arst_res_data", int'(res_data_3), 0);
        check("arst_res_ovf", int'(res_ovf_3), 0);
        check("arst_alu_a", int'(alu_a_3), 0);
        check("arst_alu_b", int'(alu_b_3), 0);
        check("arst_alu_c", int'(alu_c_3), 1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (res_valid_3 || busy_3) seen = 1'b1;
        end
        check("arst_no_result", int'(seen), 0);

        // SETTLE=3 timing: 0 - 5 = 59
        push(1, 1'b0, 2'b11, 6'd5, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) check("s3_b_before_issue", int'(alu_b_3), 0);
            if (k >= 2 && k <= 4) begin
                check($sformatf("s3_b_k%0d", k), int'(alu_b_3), 5);
                check($sformatf("s3_c_k%0d", k), int'(alu_c_3), 3);
                check($sformatf("s3_a_k%0d", k), int'(alu_a_3), 0);
            end
            if (k == 5) check("s3_acc_update", int'(alu_a_3), 59);
            if (k == 6) begin
                check("s3_res_valid", int'(res_valid_3), 1);
                check("s3_res_data", int'(res_data_3), 59);
                check("s3_res_ovf", int'(res_ovf_3), 0);
            end
        end
        res_ready_3 = 1'b1;
        tick();
        res_ready_3 = 1'b0;
        check("s3_valid_drop", int'(res_valid_3), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Command-side sequencer that is the initiator for a 6-bit, 4-op combinational ALU.
- Accepts a stream of op/operand commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's a/b/c inputs from an internal accumulator and the command, then captures F back into the accumulator.
- Returns the final accumulator value on a result handshake when a command marked last retires.

Parameters:
- WIDTH, 6, datapath width; equals the ALU operand width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- SETTLE, 1, clock cycles alu_a/alu_b/alu_c are held stable before alu_f is sampled; range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  ALU op code: 00 A+B+1, 01 A, 10 A&B, 11 A-B.
- cmd_load  in  1  1 = acc <= cmd_operand directly; the ALU is not used.
- cmd_operand  in  WIDTH  B operand, or the load value.
- cmd_last  in  1  retiring this command emits a result.
- alu_a  out  WIDTH  ALU A input; always equals acc.
- alu_b  out  WIDTH  ALU B input.
- alu_c  out  2  ALU op select.
- alu_f  in  WIDTH  ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  WIDTH  result value.
- res_ovf  out  1  sticky signed overflow; see Optional Feature.
- busy  out  1  state is not IDLE, or FIFO not empty.

Behaviour:
- Reset values: acc=0, FIFO empty, state=IDLE, alu_b=0, alu_c=2'b01, res_valid=0, res_data=0, res_ovf=0, busy=0, cmd_ready=1.
- Reset mid-operation aborts everything: the in-flight command and any pending result are discarded.
- FIFO write:
  - Occurs when cmd_valid && cmd_ready.
  - cmd_ready = !full, combinational from the count.
  - A simultaneous push and pop when full is not allowed: ready is low, so the push is refused.
  - A simultaneous push and pop when empty is impossible because the pop requires a non-empty FIFO.
  - Pointers wrap modulo FIFO_DEPTH.
- IDLE: if the FIFO is not empty, pop the head into the cur_* registers and go to ISSUE. Otherwise stay.
- ISSUE:
  - Load: acc <= cur_operand, then go to RETIRE.
  - ALU op: drive alu_b=cur_operand and alu_c=cur_op, load the settle counter with SETTLE-1, and go to WAIT.
- WAIT:
  - alu_a, alu_b and alu_c are held constant.
  - Decrement the counter; when it is 0, acc <= alu_f and go to RETIRE.
  - With SETTLE=1, the capture happens in the first WAIT cycle.
  - ALU command latency from pop to acc update is SETTLE+1 cycles.
- RETIRE:
  - If cur_last: res_data <= acc, res_valid <= 1, go to RESULT.
  - Otherwise go to IDLE.
- RESULT:
  - Hold res_valid, res_data and res_ovf stable until res_valid && res_ready.
  - On that handshake: res_valid=0, acc <= 0, clear the sticky ovf, go to IDLE.
  - The FIFO keeps accepting commands while in RESULT.
- Throughput:
  - ALU command: SETTLE+3 cycles (IDLE, ISSUE, WAIT×SETTLE, RETIRE).
  - Load: 3 cycles.
- Arithmetic is the ALU's; this block does not compute F itself and captures alu_f unmodified. Wrap-around is the ALU's mod-2^WIDTH behaviour.
- acc persists across non-last commands, so chains accumulate.
- res_data reflects acc after the last command.

Optional Feature:
- Macro: ALUSEQ_OVF_EN.
- When defined, a sticky ovf bit is set at WAIT capture, using the sign bits of alu_a, alu_b and alu_f:
  - op 00: set when a and b have equal signs and f's sign differs from a.
  - op 11: set when a and b have different signs and f's sign differs from a.
  - ops 01 and 10: never set.
- When defined, res_ovf is updated with the result in RETIRE; the sticky bit clears on the result handshake and on reset.
- When undefined: no overflow logic is built and res_ovf is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT with 3 commands queued -> all outputs at their reset values, FIFO empty, no result emitted after release.
- Chain: load 5; op00 with B=2 (5+2+1); op11 with B=3 (8-3), last -> res_data=5, res_valid held until res_ready, acc=0 afterwards.
- Wrap: load 31; op00 with B=0, last -> res_data=6'b100000 (-32); with ALUSEQ_OVF_EN res_ovf=1, without it res_ovf=0.
- AND/pass: load 6'b101101; op10 with B=6'b011011 -> acc=6'b001001; op01 with B=any, last -> res_data=6'b001001, ovf=0.
- Backpressure: push 4 commands with no pops pending -> cmd_ready=0 on the fifth; hold res_ready=0 for 10 cycles -> result stable, FIFO fills, no command lost after release.
- SETTLE=3: check alu_a, alu_b and alu_c are held exactly 3 cycles in WAIT and acc updates 4 cycles after the pop.
